// File: rtl/mem_range_fill.sv
// rtl/mem_range_fill.sv - DEPTH x WIDTH memory with a single-source range-fill engine
//
// Copies a snapshot of mem[src] into every entry of [lo,hi], one entry per cycle.
// Optional build macro MEM_RANGE_FILL_VERIFY_EN adds a VERIFY pass that re-walks
// the range and raises a sticky err on any entry that differs from the snapshot.
//
// Ports:
//   clk      in  1      rising-edge clock
//   rst      in  1      synchronous active-high reset
//   wr_en    in  1      host write strobe, honoured only in IDLE
//   wr_addr  in  AW     host write address
//   wr_data  in  WIDTH  host write data
//   rd_addr  in  AW     host read address
//   rd_data  out WIDTH  registered read data, 1-cycle latency
//   start    in  1      range-fill request, honoured only in IDLE
//   lo       in  AW     first range index (inclusive)
//   hi       in  AW     last range index (inclusive)
//   src      in  AW     source entry index
//   busy     out 1      high in FILL and VERIFY
//   done     out 1      one-cycle completion pulse
//   err      out 1      sticky verify mismatch flag (tied 0 without the macro)

module mem_range_fill #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             start,
    input  logic [AW-1:0]    lo,
    input  logic [AW-1:0]    hi,
    input  logic [AW-1:0]    src,
    output logic             busy,
    output logic             done,
    output logic             err
);

`ifdef MEM_RANGE_FILL_VERIFY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_VERIFY = 2'd2,
        S_DONE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_DONE   = 2'd3
    } state_t;
`endif

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_snap;
    logic [WIDTH-1:0] r_rd_data;
    logic [AW-1:0]    r_hi;
    // One extra bit so hi = DEPTH-1 is reached without the walk index wrapping.
    logic [AW:0]      r_i;
    logic             w_last;
    logic             w_fill_we;
    logic             w_host_we;

    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    assign w_last    = (r_i == {1'b0, r_hi});
    assign w_host_we = wr_en && (r_state == S_IDLE) && !rst;

    always_comb begin
        w_state_nxt = r_state;
        w_fill_we   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (lo > hi) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                w_fill_we = 1'b1;
                if (w_last) begin
`ifdef MEM_RANGE_FILL_VERIFY_EN
                    w_state_nxt = S_VERIFY;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
`ifdef MEM_RANGE_FILL_VERIFY_EN
            S_VERIFY: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
`endif
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Memory is never reset; a fill write already under way at a reset edge
    // still lands, only the host port is gated by rst.
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_mem[r_i[AW-1:0]] <= r_snap;
        end else if (w_host_we) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

`ifdef MEM_RANGE_FILL_VERIFY_EN
    logic [AW-1:0] r_lo;
    logic          r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lo  <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_lo <= lo;
            end
            if (r_state == S_VERIFY && r_mem[r_i[AW-1:0]] != r_snap) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_i       <= '0;
            r_hi      <= '0;
            r_snap    <= '0;
            r_rd_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_data <= r_mem[rd_addr];
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_hi   <= hi;
                        r_snap <= r_mem[src];
                        r_i    <= {1'b0, lo};
                    end
                end
                S_FILL: begin
`ifdef MEM_RANGE_FILL_VERIFY_EN
                    // Rewind to the range start for the verify walk.
                    r_i <= w_last ? {1'b0, r_lo} : r_i + ONE;
`else
                    if (!w_last) begin
                        r_i <= r_i + ONE;
                    end
`endif
                end
`ifdef MEM_RANGE_FILL_VERIFY_EN
                S_VERIFY: begin
                    if (!w_last) begin
                        r_i <= r_i + ONE;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign rd_data = r_rd_data;
    assign busy    = (r_state == S_FILL)
`ifdef MEM_RANGE_FILL_VERIFY_EN
                   || (r_state == S_VERIFY)
`endif
                   ;
    assign done    = (r_state == S_DONE);

endmodule

// File: tb/tb_mem_range_fill.sv
// tb/tb_mem_range_fill.sv - self-checking bench for mem_range_fill

module tb_mem_range_fill;

`ifdef MEM_RANGE_FILL_VERIFY_EN
    localparam int VF = 1;
`else
    localparam int VF = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic [1:0] rd_addr;
    logic [3:0] rd_data;
    logic       start;
    logic [1:0] lo;
    logic [1:0] hi;
    logic [1:0] src;
    logic       busy;
    logic       done;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] model [4];

    mem_range_fill #(.WIDTH(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .start(start), .lo(lo), .hi(hi), .src(src),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pre;
        logic [1:0]  lo;
        logic [1:0]  hi;
        logic [1:0]  src;
        int          lat;
        logic [15:0] post;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [1:0] a, input logic [3:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
        model[a] = d;
    endtask

    task automatic check_mem(input string tag);
        for (int a = 0; a < 4; a++) begin
            rd_addr = a[1:0];
            step();
            check($sformatf("%s mem[%0d]", tag, a), int'(rd_data), int'(model[a]));
        end
    endtask

    // Drives one fill request and checks busy/done each cycle against the
    // expected done cycle; optionally pokes start and wr_en while busy.
    task automatic run_fill(input string tag, input logic [1:0] l, input logic [1:0] h,
                            input logic [1:0] s, input int lat, input bit inject);
        logic [3:0] snap;
        start = 1'b1; lo = l; hi = h; src = s;
        step();
        start = 1'b0;
        snap = model[s];
        if (l <= h) begin
            for (int j = int'(l); j <= int'(h); j++) model[j] = snap;
        end
        for (int c = 1; c <= lat + 1; c++) begin
            check($sformatf("%s busy@T+%0d", tag, c), int'(busy), (c < lat) ? 1 : 0);
            check($sformatf("%s done@T+%0d", tag, c), int'(done), (c == lat) ? 1 : 0);
            if (inject && c == 1) begin
                start = 1'b1; lo = 2'd0; hi = 2'd0; src = 2'd0;
                wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'hF;
            end
            step();
            start = 1'b0;
            wr_en = 1'b0;
        end
        check({tag, " err"}, int'(err), 0);
    endtask

    vec_t vecs [6];

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; start = 1'b0; lo = '0; hi = '0; src = '0;
        step();
        step();
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset err", int'(err), 0);
        check("reset rd_data", int'(rd_data), 0);
        rst = 1'b0;

        vecs[0] = '{16'h3215, 2'd2, 2'd3, 2'd0, 3 + 2*VF, 16'h5515};
        vecs[1] = '{16'h3215, 2'd3, 2'd1, 2'd0, 1,        16'h3215};
        vecs[2] = '{16'h7694, 2'd0, 2'd3, 2'd1, 5 + 4*VF, 16'h9999};
        vecs[3] = '{16'hABCD, 2'd3, 2'd3, 2'd0, 2 + VF,   16'hDBCD};
        vecs[4] = '{16'h1234, 2'd0, 2'd0, 2'd3, 2 + VF,   16'h1231};
        vecs[5] = '{16'h8421, 2'd1, 2'd2, 2'd2, 3 + 2*VF, 16'h8441};

        for (int v = 0; v < 6; v++) begin
            logic [15:0] pre;
            logic [15:0] post;
            pre  = vecs[v].pre;
            post = vecs[v].post;
            for (int a = 0; a < 4; a++) host_write(a[1:0], pre[4*a +: 4]);
            run_fill($sformatf("vec%0d", v), vecs[v].lo, vecs[v].hi, vecs[v].src,
                     vecs[v].lat, 1'b0);
            for (int a = 0; a < 4; a++) begin
                rd_addr = a[1:0];
                step();
                check($sformatf("vec%0d mem[%0d]", v, a), int'(rd_data), int'(post[4*a +: 4]));
            end
        end

        // Randomized requests against the array model.
        for (int r = 0; r < 25; r++) begin
            logic [1:0] l, h, s;
            int n;
            if ($urandom_range(0, 1) == 1)
                host_write(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            l = 2'($urandom_range(0, 3));
            h = 2'($urandom_range(0, 3));
            s = 2'($urandom_range(0, 3));
            n = int'(h) - int'(l) + 1;
            run_fill($sformatf("rnd%0d", r), l, h, s, (l > h) ? 1 : n * (1 + VF) + 1, 1'b0);
            check_mem($sformatf("rnd%0d", r));
        end

        // Host write in the same cycle as reset is dropped.
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = ~model[2];
        step();
        rst = 1'b0; wr_en = 1'b0;
        check_mem("wr_rst");

        // Reset two edges into a 4-entry fill: entries 0 and 1 already filled.
        host_write(2'd0, 4'h7); host_write(2'd1, 4'h2);
        host_write(2'd2, 4'h3); host_write(2'd3, 4'h4);
        start = 1'b1; lo = 2'd0; hi = 2'd3; src = 2'd0;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst busy", int'(busy), 0);
        check("midrst done", int'(done), 0);
        step();
        check("midrst done+1", int'(done), 0);
        model[0] = 4'h7; model[1] = 4'h7;
        check_mem("midrst");

        // start and wr_en pulsed during a fill are both ignored.
        host_write(2'd0, 4'h1); host_write(2'd1, 4'h2);
        host_write(2'd2, 4'h3); host_write(2'd3, 4'h4);
        run_fill("inject", 2'd1, 2'd3, 2'd3, 3 * (1 + VF) + 1, 1'b1);
        check_mem("inject");

`ifdef MEM_RANGE_FILL_VERIFY_EN
        // Corrupt an entry behind the engine's back during VERIFY.
        host_write(2'd0, 4'h6); host_write(2'd1, 4'h1);
        host_write(2'd2, 4'h2); host_write(2'd3, 4'h3);
        start = 1'b1; lo = 2'd0; hi = 2'd3; src = 2'd0;
        step();
        start = 1'b0;
        for (int c = 0; c < 4; c++) step();
        check("vfy busy in verify", int'(busy), 1);
        check("vfy err before", int'(err), 0);
        dut.r_mem[3] = 4'h9;
        for (int c = 0; c < 4; c++) step();
        check("vfy done", int'(done), 1);
        check("vfy err set", int'(err), 1);
        step();
        step();
        check("vfy err sticky", int'(err), 1);
        model[0] = 4'h6; model[1] = 4'h6; model[2] = 4'h6; model[3] = 4'h9;
        check_mem("vfy");
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("vfy err cleared", int'(err), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
